// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg
//   Shared definitions for the UART register-access frame responder:
//   FSM state encoding, default protocol bytes, CMD field positions and
//   a helper that tells which states are waiting on host bytes.
package uart_frame_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR_H,
    S_ADDR_L,
    S_WDATA_H,
    S_WDATA_L,
    S_RD_REQ,
    S_RD_WAIT,
    S_TX_H,
    S_TX_L
  } state_t;

  localparam logic [7:0]  SOF_BYTE_DEF    = 8'hAA;
  localparam logic [7:0]  RSP_BYTE_DEF    = 8'h55;
  localparam int unsigned TIMEOUT_CYC_DEF = 200000;

  // CMD byte layout: {rw, 3'b000, len[3:0]}
  localparam int RW_BIT  = 7;
  localparam int LEN_MSB = 3;

  // States in which the engine is waiting for the next host byte.
  function automatic logic in_rx_phase(input state_t s);
    return (s == S_CMD) || (s == S_ADDR_H) || (s == S_ADDR_L) ||
           (s == S_WDATA_H) || (s == S_WDATA_L);
  endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// uart_frame_timeout
//   Inter-byte watchdog. Counts clk cycles while count_en is high and
//   raises expired on the TIMEOUT_CYC-th consecutive counted cycle.
//   clear (a received byte) or count_en low restarts the count.
//   With ENABLE=0 no counter exists and expired is tied low.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - restart count (byte received)
//   count_en  - engine is waiting on a host byte
//   expired   - combinational timeout indication
module uart_frame_timeout #(
  parameter int unsigned TIMEOUT_CYC = 200000,
  parameter bit          ENABLE      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  generate
    if (ENABLE) begin : g_cnt
      localparam int CW = $clog2(TIMEOUT_CYC + 1);
      logic [CW-1:0] cnt;

      assign expired = count_en && !clear && (cnt == CW'(TIMEOUT_CYC - 1));

      always_ff @(posedge clk) begin
        if (rst || clear || !count_en || expired) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end else begin : g_off
      logic unused_in;
      assign unused_in = ^{clk, rst, clear, count_en, (TIMEOUT_CYC != 0)};
      assign expired   = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/uart_frame_responder.sv
// uart_frame_responder
//   Device-side command engine for the UART register-access protocol.
//   Parses host frames SOF, CMD{rw,000,len}, ADDR_H, ADDR_L [, data words]
//   and performs len+1 register writes or reads with auto-incrementing
//   (wrapping) address. Read data goes back as RSP_BYTE then hi/lo bytes.
//
// Optional feature: define UART_FRAME_TIMEOUT_EN to abort a frame when
//   no byte arrives for TIMEOUT_CYC cycles while waiting on host bytes.
//
// Handshakes: rx_valid_i is a one-cycle strobe qualifying rx_data_i (no
//   back-pressure toward the receiver). tx_write_o is a one-cycle strobe
//   issued only in a cycle where tx_full_i was sampled low. reg_wr_o and
//   reg_rd_o are one-cycle strobes; reg_rdata_i is valid exactly the
//   cycle after reg_rd_o.
//
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   rx_data_i/rx_valid_i      - received byte stream
//   rx_break_i                - break level; aborts any active frame
//   tx_data_o/tx_write_o      - transmit buffer write port
//   tx_full_i                 - transmit buffer full
//   reg_addr_o/reg_wdata_o    - register bus address / write data
//   reg_wr_o/reg_rd_o         - register write / read strobes
//   reg_rdata_i               - register read data
//   busy_o                    - frame in progress
//   frame_err_o               - pulse on frame abort
module uart_frame_responder
  import uart_frame_pkg::*;
#(
  parameter logic [7:0]  SOF_BYTE    = SOF_BYTE_DEF,
  parameter logic [7:0]  RSP_BYTE    = RSP_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        rx_break_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_write_o,
  input  logic        tx_full_i,
  output logic [15:0] reg_addr_o,
  output logic [15:0] reg_wdata_o,
  output logic        reg_wr_o,
  output logic        reg_rd_o,
  input  logic [15:0] reg_rdata_i,
  output logic        busy_o,
  output logic        frame_err_o
);

`ifdef UART_FRAME_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_t      state;
  logic        rw;
  logic [3:0]  len;
  logic [3:0]  word_cnt;
  logic [15:0] addr;
  logic [7:0]  wdata_hi;
  logic [15:0] rdata;
  logic        need_hdr;   // response header not yet pushed for this frame
  logic        rd_armed;   // reg_rd_o issued, data arrives next cycle
  logic        timeout_hit;

  uart_frame_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .ENABLE      (TIMEOUT_EN)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear    (rx_valid_i),
    .count_en (in_rx_phase(state)),
    .expired  (timeout_hit)
  );

  assign busy_o = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rw          <= 1'b0;
      len         <= '0;
      word_cnt    <= '0;
      addr        <= '0;
      wdata_hi    <= '0;
      rdata       <= '0;
      need_hdr    <= 1'b0;
      rd_armed    <= 1'b0;
      tx_data_o   <= '0;
      tx_write_o  <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      reg_wr_o    <= 1'b0;
      reg_rd_o    <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      tx_write_o  <= 1'b0;
      reg_wr_o    <= 1'b0;
      reg_rd_o    <= 1'b0;
      frame_err_o <= 1'b0;

      // Abort takes priority over any byte or strobe decided this cycle.
      if ((state != S_IDLE) && (rx_break_i || timeout_hit)) begin
        state       <= S_IDLE;
        frame_err_o <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (rx_valid_i && (rx_data_i == SOF_BYTE)) state <= S_CMD;
          end
          S_CMD: begin
            if (rx_valid_i) begin
              rw       <= rx_data_i[RW_BIT];
              len      <= rx_data_i[LEN_MSB:0];
              word_cnt <= '0;
              need_hdr <= 1'b1;
              state    <= S_ADDR_H;
            end
          end
          S_ADDR_H: begin
            if (rx_valid_i) begin
              addr[15:8] <= rx_data_i;
              state      <= S_ADDR_L;
            end
          end
          S_ADDR_L: begin
            if (rx_valid_i) begin
              addr[7:0] <= rx_data_i;
              state     <= rw ? S_RD_REQ : S_WDATA_H;
            end
          end
          S_WDATA_H: begin
            if (rx_valid_i) begin
              wdata_hi <= rx_data_i;
              state    <= S_WDATA_L;
            end
          end
          S_WDATA_L: begin
            if (rx_valid_i) begin
              reg_wr_o    <= 1'b1;
              reg_addr_o  <= addr;
              reg_wdata_o <= {wdata_hi, rx_data_i};
              if (word_cnt == len) begin
                state <= S_IDLE;
              end else begin
                addr     <= addr + 16'd1;
                word_cnt <= word_cnt + 4'd1;
                state    <= S_WDATA_H;
              end
            end
          end
          S_RD_REQ: begin
            if (need_hdr) begin
              if (!tx_full_i) begin
                tx_data_o  <= RSP_BYTE;
                tx_write_o <= 1'b1;
                need_hdr   <= 1'b0;
              end
            end else begin
              reg_rd_o   <= 1'b1;
              reg_addr_o <= addr;
              rd_armed   <= 1'b0;
              state      <= S_RD_WAIT;
            end
          end
          S_RD_WAIT: begin
            // First cycle here carries the reg_rd_o strobe; data is on the
            // bus the following cycle.
            if (!rd_armed) begin
              rd_armed <= 1'b1;
            end else begin
              rdata <= reg_rdata_i;
              state <= S_TX_H;
            end
          end
          S_TX_H: begin
            if (!tx_full_i) begin
              tx_data_o  <= rdata[15:8];
              tx_write_o <= 1'b1;
              state      <= S_TX_L;
            end
          end
          S_TX_L: begin
            if (!tx_full_i) begin
              tx_data_o  <= rdata[7:0];
              tx_write_o <= 1'b1;
              if (word_cnt == len) begin
                state <= S_IDLE;
              end else begin
                addr     <= addr + 16'd1;
                word_cnt <= word_cnt + 4'd1;
                state    <= S_RD_REQ;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_responder.sv
// tb_uart_frame_responder
//   Self-checking bench for uart_frame_responder: directed frames from the
//   protocol description plus randomized read/write frames, compared
//   against a transaction-level model of expected register and tx traffic.
module tb_uart_frame_responder;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_break_i;
  logic [7:0]  tx_data_o;
  logic        tx_write_o;
  logic        tx_full_i;
  logic [15:0] reg_addr_o;
  logic [15:0] reg_wdata_o;
  logic        reg_wr_o;
  logic        reg_rd_o;
  logic [15:0] reg_rdata_i;
  logic        busy_o;
  logic        frame_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard queues: expected from the model, observed from the monitor.
  logic [31:0] exp_wr_q[$];
  logic [31:0] obs_wr_q[$];
  logic [15:0] exp_rd_q[$];
  logic [15:0] obs_rd_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  obs_tx_q[$];
  int          exp_err;
  int          obs_err;

  logic [15:0] wbuf[16];
  bit          rd_done;

  uart_frame_responder dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .rx_break_i  (rx_break_i),
    .tx_data_o   (tx_data_o),
    .tx_write_o  (tx_write_o),
    .tx_full_i   (tx_full_i),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_wr_o    (reg_wr_o),
    .reg_rd_o    (reg_rd_o),
    .reg_rdata_i (reg_rdata_i),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- register stub ----------------
  function automatic logic [15:0] stub_val(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Data is valid only the cycle after reg_rd_o; garbage otherwise.
  always @(posedge clk) begin
    if (reg_rd_o) reg_rdata_i <= stub_val(reg_addr_o);
    else          reg_rdata_i <= 16'hDEAD;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reg_wr_o)    obs_wr_q.push_back({reg_addr_o, reg_wdata_o});
    if (reg_rd_o)    obs_rd_q.push_back(reg_addr_o);
    if (tx_write_o)  obs_tx_q.push_back(tx_data_o);
    if (frame_err_o) obs_err++;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(negedge clk);
    rx_valid_i = 1'b0;
    rx_data_i  = 8'($urandom);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_o && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) check({tag, "_idle_timeout"}, 32'd1, 32'd0);
  endtask

  // ---------------- reference model ----------------
  // Write frame: word i lands at (addr + i) mod 2^16.
  task automatic model_write(input logic [15:0] addr, input int n);
    for (int i = 0; i < n; i++)
      exp_wr_q.push_back({16'(addr + i), wbuf[i]});
  endtask

  // Read frame: one header byte, then hi/lo of each word read.
  task automatic model_read(input logic [15:0] addr, input int n);
    exp_tx_q.push_back(8'h55);
    for (int i = 0; i < n; i++) begin
      logic [15:0] a;
      logic [15:0] v;
      a = 16'(addr + i);
      v = stub_val(a);
      exp_rd_q.push_back(a);
      exp_tx_q.push_back(v[15:8]);
      exp_tx_q.push_back(v[7:0]);
    end
  endtask

  task automatic send_frame(input bit rw, input logic [15:0] addr, input int n);
    logic [7:0] cmd;
    cmd = {rw, 3'b000, 4'(n - 1)};
    send_byte(8'hAA);
    send_byte(cmd);
    send_byte(addr[15:8]);
    send_byte(addr[7:0]);
    if (!rw) begin
      for (int i = 0; i < n; i++) begin
        send_byte(wbuf[i][15:8]);
        send_byte(wbuf[i][7:0]);
      end
    end else begin
      // Stray bytes during a read must be ignored.
      send_byte(8'h12);
      send_byte(8'h34);
    end
  endtask

  task automatic do_write(input logic [15:0] addr, input int n, input string tag);
    model_write(addr, n);
    send_frame(1'b0, addr, n);
    wait_idle(tag);
  endtask

  task automatic do_read(input logic [15:0] addr, input int n, input string tag);
    model_read(addr, n);
    send_frame(1'b1, addr, n);
    wait_idle(tag);
  endtask

  // Compare everything observed since the last scoreboard drain.
  task automatic score(input string tag);
    int n;
    cycles(4);
    check({tag, "_wr_count"}, obs_wr_q.size(), exp_wr_q.size());
    check({tag, "_rd_count"}, obs_rd_q.size(), exp_rd_q.size());
    check({tag, "_tx_count"}, obs_tx_q.size(), exp_tx_q.size());
    check({tag, "_err_count"}, obs_err, exp_err);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    n = (obs_wr_q.size() < exp_wr_q.size()) ? obs_wr_q.size() : exp_wr_q.size();
    for (int i = 0; i < n; i++) check({tag, "_wr"}, obs_wr_q[i], exp_wr_q[i]);
    n = (obs_rd_q.size() < exp_rd_q.size()) ? obs_rd_q.size() : exp_rd_q.size();
    for (int i = 0; i < n; i++) check({tag, "_rd_addr"}, 32'(obs_rd_q[i]), 32'(exp_rd_q[i]));
    n = (obs_tx_q.size() < exp_tx_q.size()) ? obs_tx_q.size() : exp_tx_q.size();
    for (int i = 0; i < n; i++) check({tag, "_tx"}, 32'(obs_tx_q[i]), 32'(exp_tx_q[i]));
    exp_wr_q.delete(); obs_wr_q.delete();
    exp_rd_q.delete(); obs_rd_q.delete();
    exp_tx_q.delete(); obs_tx_q.delete();
    exp_err = 0;       obs_err = 0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst        = 1'b1;
    rx_data_i  = 8'h00;
    rx_valid_i = 1'b0;
    rx_break_i = 1'b0;
    tx_full_i  = 1'b0;
    exp_err    = 0;
    obs_err    = 0;
    cycles(4);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_tx_data",   32'(tx_data_o),   32'd0);
    check("rst_tx_write",  32'(tx_write_o),  32'd0);
    check("rst_reg_addr",  32'(reg_addr_o),  32'd0);
    check("rst_reg_wdata", 32'(reg_wdata_o), 32'd0);
    check("rst_reg_wr",    32'(reg_wr_o),    32'd0);
    check("rst_reg_rd",    32'(reg_rd_o),    32'd0);
    check("rst_busy",      32'(busy_o),      32'd0);
    check("rst_frame_err", 32'(frame_err_o), 32'd0);
    obs_wr_q.delete(); obs_rd_q.delete(); obs_tx_q.delete(); obs_err = 0;

    // Non-SOF noise in IDLE is discarded
    send_byte(8'h55);
    send_byte(8'h00);
    check("idle_noise_busy", 32'(busy_o), 32'd0);

    // Single write
    wbuf[0] = 16'h8888;
    do_write(16'h2008, 1, "single_wr");
    score("single_wr");

    // Single read
    do_read(16'h2008, 1, "single_rd");
    score("single_rd");

    // Break mid-frame, then a clean frame
    send_byte(8'hAA);
    send_byte(8'h91);
    @(negedge clk);
    rx_break_i = 1'b1;
    cycles(40);
    rx_break_i = 1'b0;
    exp_err = 1;
    score("break");
    wbuf[0] = 16'h1357;
    do_write(16'h0040, 1, "after_break");
    score("after_break");

    // Break in IDLE does nothing
    rx_break_i = 1'b1;
    cycles(10);
    rx_break_i = 1'b0;
    score("idle_break");

    // Burst write 16 words at 0x2001
    for (int i = 0; i < 15; i++) wbuf[i] = 16'(16'h1111 * (i + 1));
    wbuf[15] = 16'hABCD;
    do_write(16'h2001, 16, "burst_wr");
    score("burst_wr");

    // Burst read of the same range with a 50-cycle tx_full stall
    fork
      do_read(16'h2001, 16, "burst_rd");
      begin
        cycles(20);
        tx_full_i = 1'b1;
        cycles(50);
        tx_full_i = 1'b0;
      end
    join
    score("burst_rd");

    // Address wrap
    wbuf[0] = 16'hC0DE;
    wbuf[1] = 16'hBEEF;
    do_write(16'hFFFF, 2, "wrap_wr");
    score("wrap_wr");
    do_read(16'hFFFE, 3, "wrap_rd");
    score("wrap_rd");

    // Reset mid-frame: no strobes, back to IDLE
    send_byte(8'hAA);
    send_byte(8'h00);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    send_byte(8'h78);
    score("mid_rst");

    // Randomized frames with random tx back-pressure on reads
    for (int f = 0; f < 14; f++) begin
      bit          rw;
      int          n;
      logic [15:0] addr;
      rw   = 1'($urandom_range(0, 1));
      n    = $urandom_range(1, 16);
      addr = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7))
                                         : 16'($urandom);
      if (!rw) begin
        for (int i = 0; i < 16; i++) wbuf[i] = 16'($urandom);
        do_write(addr, n, "rand_wr");
      end else begin
        rd_done = 1'b0;
        fork
          begin
            do_read(addr, n, "rand_rd");
            rd_done = 1'b1;
          end
          begin
            while (!rd_done) begin
              @(negedge clk);
              tx_full_i = ($urandom_range(0, 2) == 0);
            end
            tx_full_i = 1'b0;
          end
        join
      end
      score(rw ? "rand_rd" : "rand_wr");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
